// File: rtl/vga_scaled_timing_pkg.sv
// Shared widths, window defaults, scale encodings and the raster-control
// bundle for the scaled VGA timing generator.
package vga_scaled_timing_pkg;

  localparam int unsigned VGA_POSXY_BIT = 10;
  localparam int unsigned RGB_BIT       = 12;

  localparam int unsigned GAME_X_DEF = 0;
  localparam int unsigned GAME_Y_DEF = 0;
  localparam int unsigned GAME_W_DEF = 256;
  localparam int unsigned GAME_H_DEF = 240;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'd0,
    SCALE_2X   = 2'd1,
    SCALE_4X   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_sel_e;

  // Raster control bits that travel through the renderer-latency delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic win;
  } raster_ctl_t;

  // Map a scale selection to a right-shift amount; the reserved code acts as 2x.
  function automatic logic [1:0] scale_shift_of(input scale_sel_e sel);
    logic [1:0] sh;
    case (sel)
      SCALE_1X: sh = 2'd0;
      SCALE_2X: sh = 2'd1;
      SCALE_4X: sh = 2'd2;
      default:  sh = 2'd1;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vga_scaled_timing_pipe_delay.sv
// Fixed-depth shift register with asynchronous active-low reset to a
// programmable idle value. DEPTH must be at least 1.
module pipe_delay #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the input down the stage chain each clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scaled_timing.sv
// VGA raster generator with run-time 1x/2x/4x coordinate scaling, a game
// window flag, a renderer-latency delay line and registered pin outputs.
module vga_scaled_timing
  import vga_scaled_timing_pkg::*;
#(
  parameter int unsigned        H_ACTIVE   = 640,
  parameter int unsigned        H_FP       = 16,
  parameter int unsigned        H_SYNC     = 96,
  parameter int unsigned        H_BP       = 48,
  parameter int unsigned        V_ACTIVE   = 480,
  parameter int unsigned        V_FP       = 10,
  parameter int unsigned        V_SYNC     = 2,
  parameter int unsigned        V_BP       = 33,
  parameter logic               SYNC_POL   = 1'b0,
  parameter int unsigned        GAME_X     = GAME_X_DEF,
  parameter int unsigned        GAME_Y     = GAME_Y_DEF,
  parameter int unsigned        GAME_W     = GAME_W_DEF,
  parameter int unsigned        GAME_H     = GAME_H_DEF,
  parameter int unsigned        PIPE_LAT   = 2,
  parameter logic [RGB_BIT-1:0] BORDER_RGB = 12'h000
) (
  input  logic                     vga_clk,
  input  logic                     rstn,
  input  logic [1:0]               scale_sel,
  input  logic [RGB_BIT-1:0]       pixdata,
  output logic [VGA_POSXY_BIT-1:0] pos_x,
  output logic [VGA_POSXY_BIT-1:0] pos_y,
  output logic                     is_game_window,
  output logic                     frame_start,
  output logic                     line_start,
  output logic                     hsync,
  output logic                     vsync,
  output logic [RGB_BIT-1:0]       rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = VGA_POSXY_BIT;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [PW-1:0] WIN_X0 = PW'(GAME_X);
  localparam logic [PW-1:0] WIN_Y0 = PW'(GAME_Y);
  localparam logic [PW-1:0] WIN_W  = PW'(GAME_W);
  localparam logic [PW-1:0] WIN_H  = PW'(GAME_H);

  localparam raster_ctl_t CTL_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0, win: 1'b0};

  logic [HW-1:0]      r_h_cnt;
  logic [VW-1:0]      r_v_cnt;
  logic [1:0]         r_scale_shift;
  logic               r_hsync;
  logic               r_vsync;
  logic [RGB_BIT-1:0] r_rgb;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_de;
  logic [HW-1:0]      w_h_shift;
  logic [VW-1:0]      w_v_shift;
  logic [PW-1:0]      w_rel_x;
  logic [PW-1:0]      w_rel_y;
  raster_ctl_t        w_ctl;
  raster_ctl_t        w_ctl_d;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // Raster counters; the scale shift only changes as the frame wraps.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_scale_shift <= 2'd1;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      if (w_v_wrap) begin
        r_v_cnt       <= '0;
        r_scale_shift <= scale_shift_of(scale_sel_e'(scale_sel));
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_de      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_h_shift = r_h_cnt >> r_scale_shift;
  assign w_v_shift = r_v_cnt >> r_scale_shift;

  assign pos_x = w_de ? PW'(w_h_shift) : '0;
  assign pos_y = w_de ? PW'(w_v_shift) : '0;

  // Offset-then-compare: below-origin coordinates wrap high and fall outside.
  assign w_rel_x = pos_x - WIN_X0;
  assign w_rel_y = pos_y - WIN_Y0;

  assign is_game_window = w_de && (w_rel_x < WIN_W) && (w_rel_y < WIN_H);
  assign frame_start    = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign line_start     = (r_h_cnt == '0);

  // Undelayed sync/blank/window decode feeding the delay line.
  always_comb begin
    w_ctl       = CTL_IDLE;
    w_ctl.hsync = ((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_ctl.vsync = ((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_ctl.de    = w_de;
    w_ctl.win   = is_game_window;
  end

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign w_ctl_d = w_ctl;
    end else begin : g_delay
      pipe_delay #(
        .WIDTH   ($bits(raster_ctl_t)),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (CTL_IDLE)
      ) u_pipe (
        .i_clk   (vga_clk),
        .i_rst_n (rstn),
        .i_d     (w_ctl),
        .o_q     (w_ctl_d)
      );
    end
  endgenerate

  // Pin register: blank outside active video, border outside the window.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else begin
      r_hsync <= w_ctl_d.hsync;
      r_vsync <= w_ctl_d.vsync;
      r_rgb   <= w_ctl_d.de ? (w_ctl_d.win ? pixdata : BORDER_RGB) : '0;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign rgb   = r_rgb;

endmodule

// File: tb/tb_vga_scaled_timing.sv
// Scoreboard bench: two instances (latency 2 / full window / active-low sync,
// latency 0 / small window / active-high sync) on a reduced raster.
module tb_vga_scaled_timing;
  import vga_scaled_timing_pkg::*;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LA = 2;
  localparam int LB = 0;
  localparam logic [11:0] BRD_A = 12'hABC;
  localparam logic [11:0] BRD_B = 12'h0F0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int px;
    int py;
    bit de;
    bit win;
    bit hs;
    bit vs;
  } exp_t;

  logic       vga_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic [1:0] scale_sel = 2'd1;
  logic [11:0] pix_a = 12'hFFF;
  logic [11:0] pix_b = 12'hFFF;

  logic [9:0]  a_pos_x, a_pos_y, b_pos_x, b_pos_y;
  logic        a_win, a_fs, a_ls, a_hsync, a_vsync;
  logic        b_win, b_fs, b_ls, b_hsync, b_vsync;
  logic [11:0] a_rgb, b_rgb;

  always #5 vga_clk = ~vga_clk;

  vga_scaled_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PIPE_LAT(LA), .BORDER_RGB(BRD_A)
  ) u_dut_a (
    .vga_clk(vga_clk), .rstn(rstn), .scale_sel(scale_sel), .pixdata(pix_a),
    .pos_x(a_pos_x), .pos_y(a_pos_y), .is_game_window(a_win),
    .frame_start(a_fs), .line_start(a_ls),
    .hsync(a_hsync), .vsync(a_vsync), .rgb(a_rgb)
  );

  vga_scaled_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .GAME_X(10), .GAME_Y(2), .GAME_W(20), .GAME_H(10),
    .PIPE_LAT(LB), .BORDER_RGB(BRD_B)
  ) u_dut_b (
    .vga_clk(vga_clk), .rstn(rstn), .scale_sel(scale_sel), .pixdata(pix_b),
    .pos_x(b_pos_x), .pos_y(b_pos_y), .is_game_window(b_win),
    .frame_start(b_fs), .line_start(b_ls),
    .hsync(b_hsync), .vsync(b_vsync), .rgb(b_rgb)
  );

  int   total = 0;
  int   bad   = 0;
  int   m_h   = 0;
  int   m_v   = 0;
  int   m_sh  = 1;
  int   cyc   = 0;
  int   last_fs = -1;
  int   cd_215  = 0;
  out_t qa[$];
  out_t qb[$];
  logic [11:0] pha[$];
  logic [11:0] phb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d)", tag, got, exp, m_h, m_v);
    end
  endtask

  function automatic exp_t model(input int gx, input int gy, input int gw, input int gh, input bit pol);
    exp_t r;
    r.de  = (m_h < HA) && (m_v < VA);
    r.px  = r.de ? (m_h >> m_sh) : 0;
    r.py  = r.de ? (m_v >> m_sh) : 0;
    r.win = r.de && (r.px >= gx) && (r.px < gx + gw) && (r.py >= gy) && (r.py < gy + gh);
    r.hs  = ((m_h >= HA + HF) && (m_h < HA + HF + HS)) ? pol : !pol;
    r.vs  = ((m_v >= VA + VF) && (m_v < VA + VF + VS)) ? pol : !pol;
    return r;
  endfunction

  function automatic logic [11:0] pix_of(input int px, input int py);
    logic [3:0] x4, y4;
    x4 = px[3:0];
    y4 = py[3:0];
    return {x4, y4, 4'h5};
  endfunction

  function automatic int shift_of(input logic [1:0] sel);
    return (sel == 2'd0) ? 0 : (sel == 2'd2) ? 2 : 1;
  endfunction

  task automatic prefill();
    qa.delete(); qb.delete(); pha.delete(); phb.delete();
    repeat (LA + 1) qa.push_back({1'b1, 1'b1, 12'h000});
    repeat (LB + 1) qb.push_back({1'b0, 1'b0, 12'h000});
    repeat (LA) pha.push_back(12'($urandom));
    repeat (LB) phb.push_back(12'($urandom));
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_a_hsync"}, a_hsync, 1'b1);
    check({tag, "_a_vsync"}, a_vsync, 1'b1);
    check({tag, "_a_rgb"}, a_rgb, 12'h000);
    check({tag, "_b_hsync"}, b_hsync, 1'b0);
    check({tag, "_b_vsync"}, b_vsync, 1'b0);
    check({tag, "_b_rgb"}, b_rgb, 12'h000);
    check({tag, "_frame_start"}, a_fs, 1'b1);
    check({tag, "_line_start"}, a_ls, 1'b1);
    check({tag, "_pos_x"}, a_pos_x, 10'd0);
    check({tag, "_pos_y"}, a_pos_y, 10'd0);
  endtask

  // One raster cycle: optionally advance past a clock edge, then check and drive.
  task automatic step(input bit adv);
    exp_t ea, eb;
    out_t oa, ob;
    logic [11:0] pa, pb;
    if (adv) begin
      @(negedge vga_clk);
      cyc++;
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin
          m_v  = 0;
          m_sh = shift_of(scale_sel);
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    ea = model(0, 0, 256, 240, 1'b0);
    eb = model(10, 2, 20, 10, 1'b1);
    check("a_pos_x", a_pos_x, ea.px);
    check("a_pos_y", a_pos_y, ea.py);
    check("a_win", a_win, ea.win);
    check("b_pos_x", b_pos_x, eb.px);
    check("b_pos_y", b_pos_y, eb.py);
    check("b_win", b_win, eb.win);
    check("frame_start", a_fs, (m_h == 0) && (m_v == 0));
    check("line_start", b_ls, (m_h == 0));
    if (m_sh == 1 && m_v == 6) check("b_win_2x_line6", b_win, (m_h >= 20) && (m_h < 60));

    pa = pix_of(ea.px, ea.py);
    pb = pix_of(eb.px, eb.py);
    qa.push_back({ea.hs, ea.vs, ea.de ? (ea.win ? pa : BRD_A) : 12'h000});
    qb.push_back({eb.hs, eb.vs, eb.de ? (eb.win ? pb : BRD_B) : 12'h000});
    oa = qa.pop_front();
    ob = qb.pop_front();
    check("a_out", {a_hsync, a_vsync, a_rgb}, oa);
    check("b_out", {b_hsync, b_vsync, b_rgb}, ob);
    pha.push_back(pa);
    phb.push_back(pb);
    pix_a = pha.pop_front();
    pix_b = phb.pop_front();

    if (cd_215 != 0) begin
      cd_215--;
      if (cd_215 == 0) check("rgb_4x_at_8_4", a_rgb, 12'h215);
    end
    if (m_sh == 2 && m_h == 8 && m_v == 4) cd_215 = LA + 1;

    if (a_fs) begin
      if (last_fs >= 0) check("frame_len", cyc - last_fs, HT * VT);
      last_fs = cyc;
    end
  endtask

  task automatic run_until(input int v, input int h);
    int n = 0;
    while (!((m_v == v) && (m_h == h)) && (n < 2 * HT * VT)) begin
      step(1'b1);
      n++;
    end
    check("reach_target", (m_v == v) && (m_h == h), 1'b1);
  endtask

  task automatic release_reset();
    @(negedge vga_clk);
    rstn = 1'b1;
    step(1'b0);
  endtask

  initial begin
    prefill();
    repeat (3) @(negedge vga_clk);
    check_rst("por");
    release_reset();

    run_until(20, 0);
    scale_sel = 2'd2;
    run_until(0, 0);
    run_until(10, 0);
    scale_sel = 2'd1;
    run_until(0, 0);
    run_until(10, 0);
    scale_sel = 2'd0;
    run_until(0, 0);
    run_until(5, 0);
    scale_sel = 2'd3;
    run_until(0, 0);

    run_until(20, 30);
    #2 rstn = 1'b0;
    #1 check_rst("async_rst");
    m_h = 0; m_v = 0; m_sh = 1;
    cd_215 = 0; last_fs = -1;
    prefill();
    repeat (2) @(negedge vga_clk);
    check_rst("held_rst");
    release_reset();
    run_until(10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
